// File: rtl/ram_loader_16x8_pkg.sv
// ram_loader_16x8_pkg
// Shared geometry and sequencer state encoding for the 16x8 program-RAM
// loader. The SAP controller imports the same package, so the state codes
// and RAM geometry stay consistent between the two blocks.
// No ports (package).

package ram_loader_16x8_pkg;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;

    typedef logic [2:0] state_t;

    // Loader sequencer states. These are plain 3-bit constants so that
    // older tools can consume them alongside the SAP controller.
    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_ACCEPT = 3'd1;
    localparam state_t ST_SETUP  = 3'd2;
    localparam state_t ST_STROBE = 3'd3;
    localparam state_t ST_VRD    = 3'd4;
    localparam state_t ST_VCMP   = 3'd5;
    localparam state_t ST_DONE   = 3'd6;
    localparam state_t ST_ERROR  = 3'd7;

    // A state in which no session is running and i_start is honoured.
    function automatic logic is_quiescent(input state_t st);
        return (st == ST_IDLE) || (st == ST_DONE) || (st == ST_ERROR);
    endfunction

endpackage

// File: rtl/ram_loader_16x8_if.sv
// ram_loader_16x8_if
// Bundles everything the loader exchanges with the outside world apart from
// clock and reset: the byte-stream handshake, the program-RAM bus and the
// session status.
//   slave  : the loader's view (i_* inputs, o_* outputs)
//   master : the view of the block driving the stream / owning the RAM

interface ram_loader_16x8_if;
    import ram_loader_16x8_pkg::*;

    // session control and byte stream
    logic              i_start;
    logic              i_byte_valid;
    logic [DATA_W-1:0] i_byte;
    logic              i_byte_last;
    logic              o_byte_ready;

    // program-RAM side
    logic              o_ram_program_mode;
    logic [DATA_W-1:0] o_ram_data_program;
    logic [ADDR_W-1:0] o_ram_address;
    logic              o_ram_write_enable;
    logic              o_ram_read_enable;
    logic [DATA_W-1:0] i_ram_data;

    // status
    logic              o_busy;
    logic              o_done;
    logic              o_error;
    logic [ADDR_W-1:0] o_error_address;
    logic [ADDR_W:0]   o_count;

    modport slave (
        input  i_start, i_byte_valid, i_byte, i_byte_last, i_ram_data,
        output o_byte_ready, o_ram_program_mode, o_ram_data_program,
               o_ram_address, o_ram_write_enable, o_ram_read_enable,
               o_busy, o_done, o_error, o_error_address, o_count
    );

    modport master (
        output i_start, i_byte_valid, i_byte, i_byte_last, i_ram_data,
        input  o_byte_ready, o_ram_program_mode, o_ram_data_program,
               o_ram_address, o_ram_write_enable, o_ram_read_enable,
               o_busy, o_done, o_error, o_error_address, o_count
    );

endinterface

// File: rtl/ram_shadow_16x8.sv
// ram_shadow_16x8
// DEPTH x DATA_W register file holding a copy of every byte written to the
// program RAM, used as the reference during read-back verify.
// Ports:
//   clk   : clock, rising edge
//   we    : write strobe
//   waddr : write address
//   wdata : write data
//   raddr : read address (combinational read)
//   rdata : read data
// Contents have no reset; only locations written in the current session are
// ever compared.

module ram_shadow_16x8
    import ram_loader_16x8_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ram_loader_16x8.sv
// ram_loader_16x8
// Initiator-side sequencer for the 16x8 program RAM. Accepts a byte stream
// on a valid/ready handshake, writes it to addresses 0.. through the RAM
// programming path, then (VERIFY=1) reads every written location back and
// compares it with a shadow copy.
// Ports:
//   i_clk   : clock, rising edge
//   i_reset : synchronous active-high reset
//   bus     : ram_loader_16x8_if.slave (stream, RAM bus, status)
// Parameters:
//   VERIFY  : 1 = read-back verify after load, 0 = finish right after load
// All outputs come straight from flops: they are computed from the next
// state at each edge, so the RAM sees address/data settle a full cycle
// (SETUP) before the single write-enable cycle (STROBE).

module ram_loader_16x8
    import ram_loader_16x8_pkg::*;
#(
    parameter bit VERIFY = 1'b1
)
(
    input  logic                    i_clk,
    input  logic                    i_reset,
    ram_loader_16x8_if.slave        bus
);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] ptr_reg, ptr_next;
    logic              last_reg;
    logic [ADDR_W:0]   count_reg;

    logic              ready_reg;
    logic              busy_reg;
    logic              we_reg;
    logic              re_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] data_reg;
    logic              done_reg;
    logic              error_reg;
    logic [ADDR_W-1:0] err_addr_reg;

    logic              handshake;
    logic              start_ok;
    logic              mismatch;
    logic              final_byte;
    logic [DATA_W-1:0] shadow_rdata;

    // ready_reg is high exactly while in ACCEPT
    assign handshake  = bus.i_byte_valid && ready_reg;
    assign start_ok   = bus.i_start && is_quiescent(state_reg);
    assign mismatch   = (bus.i_ram_data != shadow_rdata);
    // the DEPTH-th byte closes the session even without a last flag
    assign final_byte = last_reg || (ptr_reg == ADDR_W'(DEPTH - 1));

    ram_shadow_16x8 u_shadow (
        .clk   (i_clk),
        .we    (handshake),
        .waddr (ptr_reg),
        .wdata (bus.i_byte),
        .raddr (ptr_reg),
        .rdata (shadow_rdata)
    );

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        case (state_reg)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (bus.i_start) begin
                    state_next = ST_ACCEPT;
                    ptr_next   = '0;
                end
            end
            ST_ACCEPT: begin
                if (handshake) begin
                    state_next = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_next = ST_STROBE;
            end
            ST_STROBE: begin
                if (final_byte) begin
                    ptr_next   = '0;
                    state_next = VERIFY ? ST_VRD : ST_DONE;
                end else begin
                    ptr_next   = ptr_reg + 1'b1;
                    state_next = ST_ACCEPT;
                end
            end
            ST_VRD: begin
                state_next = ST_VCMP;
            end
            ST_VCMP: begin
                if (mismatch) begin
                    state_next = ST_ERROR;
                end else if ({1'b0, ptr_reg} == count_reg - 1'b1) begin
                    state_next = ST_DONE;
                end else begin
                    ptr_next   = ptr_reg + 1'b1;
                    state_next = ST_VRD;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg    <= ST_IDLE;
            ptr_reg      <= '0;
            last_reg     <= 1'b0;
            count_reg    <= '0;
            ready_reg    <= 1'b0;
            busy_reg     <= 1'b0;
            we_reg       <= 1'b0;
            re_reg       <= 1'b0;
            addr_reg     <= '0;
            data_reg     <= '0;
            done_reg     <= 1'b0;
            error_reg    <= 1'b0;
            err_addr_reg <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;

            ready_reg <= (state_next == ST_ACCEPT);
            busy_reg  <= !is_quiescent(state_next);
            we_reg    <= (state_next == ST_STROBE);
            re_reg    <= (state_next == ST_VRD) || (state_next == ST_VCMP);

            // address moves only on entry to SETUP or VRD and is then held
            // through STROBE / VCMP
            if ((state_next == ST_SETUP) || (state_next == ST_VRD)) begin
                addr_reg <= ptr_next;
            end

            if (handshake) begin
                data_reg <= bus.i_byte;
                last_reg <= bus.i_byte_last;
            end

            if (start_ok) begin
                done_reg     <= 1'b0;
                error_reg    <= 1'b0;
                err_addr_reg <= '0;
                count_reg    <= '0;
            end

            if (state_reg == ST_STROBE) begin
                count_reg <= count_reg + 1'b1;
            end

            if ((state_next == ST_DONE) && (state_reg != ST_DONE)) begin
                done_reg <= 1'b1;
            end

            if ((state_reg == ST_VCMP) && mismatch) begin
                error_reg    <= 1'b1;
                err_addr_reg <= ptr_reg;
            end
        end
    end

    // program mode is asserted for the whole session, i.e. whenever busy
    assign bus.o_byte_ready       = ready_reg;
    assign bus.o_ram_program_mode = busy_reg;
    assign bus.o_ram_data_program = data_reg;
    assign bus.o_ram_address      = addr_reg;
    assign bus.o_ram_write_enable = we_reg;
    assign bus.o_ram_read_enable  = re_reg;
    assign bus.o_busy             = busy_reg;
    assign bus.o_done             = done_reg;
    assign bus.o_error            = error_reg;
    assign bus.o_error_address    = err_addr_reg;
    assign bus.o_count            = count_reg;

endmodule

// File: tb/tb_ram_loader_16x8.sv
// tb_ram_loader_16x8
// Table-driven bench for ram_loader_16x8: each table row is one load
// session (bytes, last flag, gaps, fault injection) with its expected
// status, write/read activity and final RAM image. Hand-written sequences
// cover reset mid-strobe and i_start while busy / in DONE.

module tb_ram_loader_16x8;
    import ram_loader_16x8_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ram_loader_16x8_if bus ();

    ram_loader_16x8 #(.VERIFY(1'b1)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus)
    );

    // ---------------- level-sensitive RAM model -----------------------
    logic [7:0] ram [16];
    logic       ram_clear = 1'b0;
    logic       stuck7 = 1'b0;
    logic [7:0] ram_rd;

    always @(posedge clk) begin
        if (ram_clear) begin
            for (int i = 0; i < 16; i++) ram[i] <= 8'h00;
        end else if (bus.o_ram_write_enable) begin
            ram[bus.o_ram_address] <= bus.o_ram_data_program;
        end
    end

    assign ram_rd = ram[bus.o_ram_address] |
                    {7'b0, stuck7 && (bus.o_ram_address == 4'd7)};
    assign bus.i_ram_data = bus.o_ram_read_enable ? ram_rd : 8'h00;

    // ---------------- protocol monitor ---------------------------------
    logic       mon_clear = 1'b0;
    int         we_cnt, hs_cnt, re_cnt, max_raddr, viol;
    logic       prev_we = 1'b0;
    logic [3:0] prev_addr = 4'd0;

    always @(negedge clk) begin
        if (mon_clear) begin
            we_cnt = 0; hs_cnt = 0; re_cnt = 0; max_raddr = -1; viol = 0;
        end else begin
            if (bus.o_ram_write_enable) begin
                we_cnt++;
                if (prev_we || prev_addr != bus.o_ram_address || !bus.o_ram_program_mode) viol++;
            end
            if (bus.o_ram_read_enable) begin
                re_cnt++;
                if (int'(bus.o_ram_address) > max_raddr) max_raddr = int'(bus.o_ram_address);
                if (!bus.o_ram_program_mode) viol++;
            end
            if (bus.o_ram_write_enable && bus.o_ram_read_enable) viol++;
            if (bus.o_byte_ready && (!bus.o_busy || !bus.o_ram_program_mode ||
                bus.o_ram_write_enable || bus.o_ram_read_enable)) viol++;
            if (bus.o_byte_ready && bus.i_byte_valid) hs_cnt++;
        end
        prev_we   = bus.o_ram_write_enable;
        prev_addr = bus.o_ram_address;
    end

    // ---------------- checking ----------------------------------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic logic [27:0] all_outputs();
        return {bus.o_byte_ready, bus.o_ram_program_mode, bus.o_ram_write_enable,
                bus.o_ram_read_enable, bus.o_ram_address, bus.o_ram_data_program,
                bus.o_busy, bus.o_done, bus.o_error, bus.o_error_address, bus.o_count};
    endfunction

    typedef struct {
        int                nbytes;
        bit                use_last;
        bit                gaps;
        bit                stuck;
        logic [15:0][7:0]  data;
        int                exp_count;
        bit                exp_done;
        bit                exp_error;
        int                exp_err_addr;
        int                exp_reads;
        int                exp_max_raddr;
    } vec_t;

    vec_t vecs [6];

    task automatic send_byte(input logic [7:0] b, input logic last, input bit gaps);
        bit hs;
        int waited;
        if (gaps) begin
            int n;
            n = int'($urandom_range(0, 3));
            for (int g = 0; g < n; g++) begin
                bus.i_byte_valid = 1'b0;
                bus.i_byte = 8'hEE;
                @(posedge clk); #1;
            end
        end
        bus.i_byte = b;
        bus.i_byte_last = last;
        bus.i_byte_valid = 1'b1;
        hs = 1'b0;
        waited = 0;
        while (!hs && waited < 50) begin
            @(negedge clk);
            hs = bus.o_byte_ready;
            @(posedge clk); #1;
            waited++;
        end
        if (!hs) check("handshake_timeout", 0, 1);
        bus.i_byte_valid = 1'b0;
        bus.i_byte_last = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int waited;
        waited = 0;
        @(negedge clk);
        while (bus.o_busy && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (bus.o_busy) check({tag, "_end_timeout"}, 0, 1);
    endtask

    task automatic session_prep(input bit stuck);
        stuck7 = stuck;
        mon_clear = 1'b1;
        ram_clear = 1'b1;
        @(posedge clk); #1;
        mon_clear = 1'b0;
        ram_clear = 1'b0;
    endtask

    task automatic pulse_start();
        bus.i_start = 1'b1;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
    endtask

    task automatic run_vec(input int k);
        string t;
        int    exp_b;
        t = $sformatf("v%0d", k);
        session_prep(vecs[k].stuck);
        pulse_start();
        for (int i = 0; i < vecs[k].nbytes; i++) begin
            send_byte(vecs[k].data[i], vecs[k].use_last && (i == vecs[k].nbytes - 1), vecs[k].gaps);
        end
        wait_idle(t);
        check({t, "_count"}, int'(bus.o_count), vecs[k].exp_count);
        check({t, "_done"}, int'(bus.o_done), int'(vecs[k].exp_done));
        check({t, "_error"}, int'(bus.o_error), int'(vecs[k].exp_error));
        if (vecs[k].exp_error)
            check({t, "_err_addr"}, int'(bus.o_error_address), vecs[k].exp_err_addr);
        check({t, "_we_cycles"}, we_cnt, vecs[k].exp_count);
        check({t, "_handshakes"}, hs_cnt, vecs[k].exp_count);
        check({t, "_re_cycles"}, re_cnt, 2 * vecs[k].exp_reads);
        check({t, "_max_read_addr"}, max_raddr, vecs[k].exp_max_raddr);
        check({t, "_protocol_viol"}, viol, 0);
        check({t, "_ready_after"}, int'(bus.o_byte_ready), 0);
        for (int a = 0; a < 16; a++) begin
            exp_b = (a < vecs[k].exp_count) ? int'(vecs[k].data[a]) : 0;
            check($sformatf("%s_ram%0d", t, a), int'(ram[a]), exp_b);
        end
        $display("session %s: count=%0d done=%0d error=%0d err_addr=%0d writes=%0d reads=%0d",
                 t, bus.o_count, bus.o_done, bus.o_error, bus.o_error_address, we_cnt, re_cnt / 2);
    endtask

    initial begin
        logic [7:0] rst_bytes [5];
        int waited;

        // ---- vector table ----
        for (int k = 0; k < 6; k++) begin
            vecs[k].data = '0; vecs[k].use_last = 1'b0; vecs[k].gaps = 1'b0;
            vecs[k].stuck = 1'b0; vecs[k].exp_error = 1'b0; vecs[k].exp_err_addr = 0;
            vecs[k].exp_done = 1'b1;
        end
        // full 16, no last flag
        vecs[0].nbytes = 16;
        for (int i = 0; i < 16; i++) vecs[0].data[i] = 8'(8'h10 + i);
        vecs[0].exp_count = 16; vecs[0].exp_reads = 16; vecs[0].exp_max_raddr = 15;
        // short program ended by last flag
        vecs[1].nbytes = 3; vecs[1].use_last = 1'b1;
        vecs[1].data[0] = 8'hA5; vecs[1].data[1] = 8'h5A; vecs[1].data[2] = 8'hFF;
        vecs[1].exp_count = 3; vecs[1].exp_reads = 3; vecs[1].exp_max_raddr = 2;
        // stuck-at-1 bit at address 7
        vecs[2].nbytes = 16; vecs[2].stuck = 1'b1;
        vecs[2].exp_count = 16; vecs[2].exp_done = 1'b0; vecs[2].exp_error = 1'b1;
        vecs[2].exp_err_addr = 7; vecs[2].exp_reads = 8; vecs[2].exp_max_raddr = 7;
        // same as vector 0 with random idle gaps
        vecs[3] = vecs[0]; vecs[3].gaps = 1'b1;
        // single byte with last
        vecs[4].nbytes = 1; vecs[4].use_last = 1'b1; vecs[4].data[0] = 8'h3C;
        vecs[4].exp_count = 1; vecs[4].exp_reads = 1; vecs[4].exp_max_raddr = 0;
        // full 16 with last flag on the 16th byte
        vecs[5].nbytes = 16; vecs[5].use_last = 1'b1;
        for (int i = 0; i < 16; i++) vecs[5].data[i] = 8'(8'hC3 + 7 * i);
        vecs[5].exp_count = 16; vecs[5].exp_reads = 16; vecs[5].exp_max_raddr = 15;

        bus.i_start = 1'b0; bus.i_byte_valid = 1'b0; bus.i_byte = 8'h00; bus.i_byte_last = 1'b0;

        // ---- reset state ----
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", int'(all_outputs()), 0);
        reset = 1'b0;

        for (int k = 0; k < 6; k++) run_vec(k);

        // ---- reset during STROBE of the 5th byte ----
        session_prep(1'b0);
        pulse_start();
        rst_bytes = '{8'h21, 8'h32, 8'h43, 8'h54, 8'h65};
        for (int i = 0; i < 5; i++) send_byte(rst_bytes[i], 1'b0, 1'b0);
        @(posedge clk); #1;
        check("rst_in_strobe_we", int'(bus.o_ram_write_enable), 1);
        check("rst_in_strobe_addr", int'(bus.o_ram_address), 4);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_outputs", int'(all_outputs()), 0);
        reset = 1'b0;
        for (int a = 0; a < 4; a++)
            check($sformatf("rst_ram%0d", a), int'(ram[a]), int'(rst_bytes[a]));
        $display("reset mid-strobe: outputs=%07h ram4=%02h", all_outputs(), ram[4]);
        run_vec(0);

        // ---- i_start while busy is ignored; i_start in DONE restarts ----
        session_prep(1'b0);
        pulse_start();
        send_byte(8'h11, 1'b0, 1'b0);
        send_byte(8'h22, 1'b0, 1'b0);
        waited = 0;
        @(negedge clk);
        while (!bus.o_byte_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        bus.i_start = 1'b1;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        check("busy_start_count", int'(bus.o_count), 2);
        check("busy_start_ready", int'(bus.o_byte_ready), 1);
        send_byte(8'h33, 1'b1, 1'b0);
        wait_idle("busy_start");
        check("busy_start_done", int'(bus.o_done), 1);
        check("busy_start_final_count", int'(bus.o_count), 3);
        check("busy_start_ram2", int'(ram[2]), 8'h33);
        $display("start-in-accept: count=%0d done=%0d", bus.o_count, bus.o_done);

        @(posedge clk); #1;
        pulse_start();
        check("restart_done_clr", int'(bus.o_done), 0);
        check("restart_count_clr", int'(bus.o_count), 0);
        check("restart_ready", int'(bus.o_byte_ready), 1);
        send_byte(8'h44, 1'b1, 1'b0);
        wait_idle("restart");
        check("restart_done", int'(bus.o_done), 1);
        check("restart_count", int'(bus.o_count), 1);
        check("restart_ram0", int'(ram[0]), 8'h44);
        $display("restart-from-done: count=%0d done=%0d ram0=%02h", bus.o_count, bus.o_done, ram[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_loader_16x8.md
Name: ram_loader_16x8

Overview:
Initiator-side sequencer for the 16x8 program RAM. It accepts a byte stream over a valid/ready handshake and writes the bytes to consecutive addresses from 0 through the RAM's dedicated programming path (program mode plus program-data bus). It then reads back every written location and compares it against a shadow copy, reporting done or the first failing address. It replaces hand-toggled programming switches when loading SAP programs.

Parameters:
DEPTH, 16, number of RAM locations loaded at most
ADDR_W, 4, RAM address width (log2 DEPTH)
DATA_W, 8, RAM word width
VERIFY, 1, 1 = run read-back verify after load; 0 = go directly to DONE

Ports:
i_clk  in  1  single system clock, rising edge
i_reset  in  1  synchronous, active-high reset
i_start  in  1  begin a load session; honoured only in IDLE, DONE or ERROR
i_byte_valid  in  1  source presents i_byte
i_byte  in  DATA_W  byte to load
i_byte_last  in  1  qualifies i_byte as the final byte of the program
o_byte_ready  out  1  loader will accept i_byte this cycle
o_ram_program_mode  out  1  to RAM program-mode select
o_ram_data_program  out  DATA_W  to RAM program-data input
o_ram_address  out  ADDR_W  to RAM address
o_ram_write_enable  out  1  to RAM write enable
o_ram_read_enable  out  1  to RAM read enable
i_ram_data  in  DATA_W  RAM data bus sampled during verify
o_busy  out  1  session in progress
o_done  out  1  sticky: load (and verify) passed
o_error  out  1  sticky: verify mismatch
o_error_address  out  ADDR_W  address of first mismatch
o_count  out  ADDR_W+1  bytes written this session (0..DEPTH)

Behaviour:
- Reset: state = IDLE. All outputs 0, o_count 0. Shadow contents are don't-care. A reset mid-session takes effect at the next edge: write enable drops immediately and RAM is left partially written (no rollback).
- All RAM-side outputs are registered. The RAM is level-sensitive, so address and data are stable one cycle before write enable rises and for the whole write-enable cycle.
- States: IDLE, ACCEPT, SETUP, STROBE, VRD, VCMP, DONE, ERROR.
- IDLE/DONE/ERROR:
  - program_mode = 0, write enable = 0, read enable = 0, o_busy = 0.
  - i_start -> ACCEPT. Clears o_done, o_error, o_error_address and o_count. Address pointer set to 0.
- ACCEPT:
  - o_byte_ready = 1, program_mode = 1, o_busy = 1.
  - On valid && ready: latch i_byte into o_ram_data_program and shadow[ptr], latch i_byte_last, then -> SETUP.
  - With no valid, stay indefinitely.
- SETUP: o_ram_address = ptr, write enable = 0. -> STROBE.
- STROBE:
  - write enable = 1 for exactly one cycle. o_count increments.
  - If last was latched or ptr == DEPTH-1: go to VRD with ptr = 0 (VERIFY = 1), or DONE (VERIFY = 0).
  - Otherwise ptr+1 -> ACCEPT.
  - Minimum cost is 3 cycles per byte.
- Auto-terminate: the 16th byte ends the session whether or not i_byte_last is set. Ready stays 0 afterwards.
- VRD: program_mode = 1, read enable = 1, o_ram_address = ptr. -> VCMP.
- VCMP:
  - read enable stays 1 and i_ram_data is sampled.
  - On mismatch with shadow[ptr]: o_error_address = ptr -> ERROR. Verify stops at the first mismatch.
  - On match: if ptr == o_count-1 -> DONE, else ptr+1 -> VRD.
- Write enable and read enable are never asserted in the same cycle. Read enable is never asserted outside VRD/VCMP.
- i_start in any busy state is ignored.
- i_start and i_reset in the same cycle: reset wins.
- Entering DONE sets o_done = 1. Entering ERROR sets o_error = 1. Both hold until the next i_start or reset.

Decomposition:
- Shared package holds the state enum (ST_IDLE … ST_ERROR) and the DEPTH/ADDR_W/DATA_W constants, reused by the SAP controller.
- One natural sub-module: ram_shadow_16x8, a DEPTH x DATA_W register file with clocked write and combinational read, sync-reset free.

Test Plan:
1. Start, stream 0x10..0x1F back-to-back with no last flag -> RAM model holds [i] = 0x10+i. Write enable high exactly 16 cycles, each preceded by a setup cycle at the same address. Verify reads 16 locations. o_done = 1, o_error = 0, o_count = 16.
2. Stream 0xA5, 0x5A, 0xFF with last on 0xFF -> o_count = 3, RAM[3..15] untouched (0). Verify reads addresses 0..2 only. o_done = 1.
3. RAM model with bit 0 stuck-at-1 at address 7, load all 0x00 -> o_error = 1, o_error_address = 7, o_done = 0. Read enable is never asserted for addresses above 7.
4. i_byte_valid toggled randomly with idle gaps -> no write without a handshake, final contents identical to test 1. o_byte_ready is never high outside ACCEPT.
5. Assert i_reset during the STROBE of the 5th byte -> next cycle all outputs 0 and IDLE. RAM[0..3] written, RAM[4] possibly written. A new start reloads from address 0 and passes.
6. Pulse i_start while in ACCEPT -> ignored (o_count unaffected). i_start in DONE -> o_done clears and a new session begins.
